// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and region map for the ROM download router
package rom_dl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2,
      RUN  = 2'd3
   } state_t;

   // Inclusive address windows of the four ROM regions inside the image
   localparam logic [15:0] PGM_BASE  = 16'h0000;
   localparam logic [15:0] PGM_LIMIT = 16'h3FFF;
   localparam logic [15:0] R1K_BASE  = 16'h4000;
   localparam logic [15:0] R1K_LIMIT = 16'h4FFF;
   localparam logic [15:0] R1H_BASE  = 16'h5000;
   localparam logic [15:0] R1H_LIMIT = 16'h5FFF;
   localparam logic [15:0] R6L_BASE  = 16'h6000;
   localparam logic [15:0] R6L_LIMIT = 16'h601F;

   // One-hot loader selects, {6L,1H,1K,PGM}
   localparam logic [3:0] SEL_NONE = 4'b0000;
   localparam logic [3:0] SEL_PGM  = 4'b0001;
   localparam logic [3:0] SEL_1K   = 4'b0010;
   localparam logic [3:0] SEL_1H   = 4'b0100;
   localparam logic [3:0] SEL_6L   = 4'b1000;

endpackage

// File: rtl/rom_region_decode.sv
// rtl/rom_region_decode.sv - maps an ioctl byte address onto a ROM region and offset
module rom_region_decode
   import rom_dl_pkg::*;
(
   input  logic [24:0] addr,
   output logic [3:0]  sel,
   output logic [15:0] offset,
   output logic        out_of_range
);

   // Walk the regions in ascending order; anything past 6L or above 64K is rejected
   always_comb begin
      sel          = SEL_NONE;
      offset       = 16'h0000;
      out_of_range = 1'b0;
      if (addr[24:16] != 9'd0) begin
         out_of_range = 1'b1;
      end else if (addr[15:0] <= PGM_LIMIT) begin
         sel    = SEL_PGM;
         offset = addr[15:0] - PGM_BASE;
      end else if (addr[15:0] <= R1K_LIMIT) begin
         sel    = SEL_1K;
         offset = addr[15:0] - R1K_BASE;
      end else if (addr[15:0] <= R1H_LIMIT) begin
         sel    = SEL_1H;
         offset = addr[15:0] - R1H_BASE;
      end else if (addr[15:0] <= R6L_LIMIT) begin
         sel    = SEL_6L;
         offset = addr[15:0] - R6L_BASE;
      end else begin
         out_of_range = 1'b1;
      end
   end

endmodule

// File: rtl/rom_dl_router.sv
// rtl/rom_dl_router.sv - routes the OSD ROM download into the core loaders and gates core reset
module rom_dl_router
   import rom_dl_pkg::*;
#(
   parameter logic [7:0]  ROM_INDEX     = 8'd0,
   parameter logic [16:0] EXPECTED_SIZE = 17'h06020,
   parameter int          HOLD_CYCLES   = 16
)(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        rom_wr,
   output logic [15:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic [3:0]  rom_sel,
   output logic        core_reset,
   output logic        dl_done,
   output logic [1:0]  dl_err,
   output logic [16:0] byte_count
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   state_t        state;
   state_t        state_next;
   logic          dl_q;
   logic [HW-1:0] hold_cnt;
   logic          rise;
   logic          fall;
   logic          hit;
   logic          accept;
   logic          bad;
   logic          hold_last;
   logic [16:0]   count_next;
   logic [3:0]    dec_sel;
   logic [15:0]   dec_off;
   logic          dec_oor;

   rom_region_decode u_decode (
      .addr         (ioctl_addr),
      .sel          (dec_sel),
      .offset       (dec_off),
      .out_of_range (dec_oor)
   );

   assign rise       = ioctl_download & ~dl_q;
   assign fall       = ~ioctl_download & dl_q;
   assign hit        = (state == LOAD) && ioctl_wr && (ioctl_index == ROM_INDEX);
   assign accept     = hit & ~dec_oor;
   assign bad        = hit & dec_oor;
   assign hold_last  = (hold_cnt == HW'(HOLD_CYCLES - 1));
   // Count including the byte accepted this cycle, so a write coincident with the fall is counted
   assign count_next = (accept && (byte_count != 17'h1FFFF)) ? byte_count + 17'd1 : byte_count;

   // Delayed download level; tracks the input through reset so a level already high is not an edge
   always_ff @(posedge clk_sys) begin
      dl_q <= ioctl_download;
   end

   // State register
   always_ff @(posedge clk_sys) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (rise) state_next = LOAD;
         LOAD: if (fall) state_next = HOLD;
         HOLD: if (hold_last) state_next = (dl_err == 2'b00) ? RUN : IDLE;
         RUN:  if (rise) state_next = LOAD;
         default: state_next = IDLE;
      endcase
   end

   // Core is released only while running a validated image
   always_comb begin
      core_reset = (state != RUN);
      dl_done    = (state == RUN);
   end

   // Post-download hold counter, parked at zero outside HOLD
   always_ff @(posedge clk_sys) begin
      if (reset || (state != HOLD)) hold_cnt <= '0;
      else if (!hold_last)          hold_cnt <= hold_cnt + 1'b1;
   end

   // Byte count and sticky error flags, cleared when a new download starts
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         byte_count <= 17'd0;
         dl_err     <= 2'b00;
      end else if (((state == IDLE) || (state == RUN)) && rise) begin
         byte_count <= 17'd0;
         dl_err     <= 2'b00;
      end else if (state == LOAD) begin
         byte_count <= count_next;
         if (bad) dl_err[0] <= 1'b1;
         if (fall && (count_next != EXPECTED_SIZE)) dl_err[1] <= 1'b1;
      end
   end

   // Registered write strobe toward the core loaders, one cycle behind ioctl_wr
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rom_wr   <= 1'b0;
         rom_sel  <= SEL_NONE;
         rom_addr <= 16'h0000;
         rom_data <= 8'h00;
      end else begin
         rom_wr  <= accept;
         rom_sel <= accept ? dec_sel : SEL_NONE;
         if (accept) begin
            rom_addr <= dec_off;
            rom_data <= ioctl_dout;
         end
      end
   end

endmodule

// File: tb/tb_rom_dl_router.sv
// tb/tb_rom_dl_router.sv - self-checking bench for rom_dl_router
module tb_rom_dl_router;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic        rom_wr;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic [3:0]  rom_sel;
   logic        core_reset;
   logic        dl_done;
   logic [1:0]  dl_err;
   logic [16:0] byte_count;

   int checks = 0;
   int errors = 0;

   // Reference state: what a correct router has accepted so far in this download
   int unsigned m_count = 0;
   logic        m_err0 = 1'b0;
   bit          m_loading = 1'b0;

   int unsigned reg_base [4] = '{32'h0000, 32'h4000, 32'h5000, 32'h6000};
   int unsigned reg_size [4] = '{32'h4000, 32'h1000, 32'h1000, 32'h0020};

   rom_dl_router dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .rom_wr         (rom_wr),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .rom_sel        (rom_sel),
      .core_reset     (core_reset),
      .dl_done        (dl_done),
      .dl_err         (dl_err),
      .byte_count     (byte_count)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Region lookup from the image map: {hit, one-hot select, offset}
   function automatic logic [20:0] model_map(input logic [24:0] a);
      int unsigned av;
      av = 32'(a);
      model_map = '0;
      for (int k = 0; k < 4; k++) begin
         if (av >= reg_base[k] && av < reg_base[k] + reg_size[k])
            model_map = {1'b1, 4'(1 << k), 16'(av - reg_base[k])};
      end
   endfunction

   task automatic send(input logic [24:0] a, input logic [7:0] d, input logic [7:0] idx, input string tag);
      logic [20:0] m;
      logic        acc;
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_index = idx;
      ioctl_wr    = 1'b1;
      m   = model_map(a);
      acc = m_loading && (idx == 8'd0) && m[20];
      if (m_loading && (idx == 8'd0) && !m[20]) m_err0 = 1'b1;
      if (acc && m_count != 32'h1FFFF) m_count++;
      tick();
      if (acc)
         chk({tag, " strobe"}, 32'({rom_wr, rom_sel, rom_addr, rom_data}), 32'({1'b1, m[19:16], m[15:0], d}));
      else
         chk({tag, " no strobe"}, 32'({rom_wr, rom_sel}), 32'd0);
      chk({tag, " count"}, 32'(byte_count), m_count);
   endtask

   task automatic start_dl();
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b1;
      tick();
      m_loading = 1'b1;
      m_count   = 0;
      m_err0    = 1'b0;
   endtask

   task automatic end_dl();
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      tick();
      m_loading = 1'b0;
   endtask

   function automatic logic [1:0] model_err();
      return {(m_count != 32'h6020), m_err0};
   endfunction

   // Called one edge after the fall has been seen; HOLD then lasts the remaining cycles
   task automatic check_hold_exit(input logic expect_run, input string tag);
      repeat (15) tick();
      chk({tag, " core_reset in hold"}, 32'(core_reset), 32'd1);
      tick();
      chk({tag, " core_reset after hold"}, 32'(core_reset), 32'(!expect_run));
      chk({tag, " dl_done after hold"}, 32'(dl_done), 32'(expect_run));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " strobe regs"}, 32'({rom_wr, rom_sel, rom_addr, rom_data}), 32'd0);
      chk({tag, " core_reset"}, 32'(core_reset), 32'd1);
      chk({tag, " dl_done"}, 32'(dl_done), 32'd0);
      chk({tag, " dl_err"}, 32'(dl_err), 32'd0);
      chk({tag, " byte_count"}, 32'(byte_count), 32'd0);
   endtask

   initial begin
      int kind;
      logic [24:0] ra;
      logic [7:0]  ri;

      reset = 1'b1;
      repeat (3) tick();
      check_reset_vals("reset");
      reset = 1'b0;
      tick();

      send(25'h00100, 8'h11, 8'd0, "wr without download");
      ioctl_wr = 1'b0;

      start_dl();
      send(25'h00200, 8'h22, 8'd1, "wrong index");
      ioctl_wr = 1'b0;
      tick();
      send(25'h04005, 8'hA5, 8'd0, "addr 4005");
      ioctl_wr = 1'b0;
      tick();
      chk("single strobe", 32'(rom_wr), 32'd0);
      send(25'h06020, 8'h33, 8'd0, "addr 6020");
      send(25'h10000, 8'h44, 8'd0, "addr 10000");
      ioctl_wr = 1'b0;
      chk("range flag", 32'(dl_err), 32'(2'b01));
      end_dl();
      chk("err dl flags", 32'(dl_err), 32'(model_err()));
      check_hold_exit(1'b0, "err dl");

      start_dl();
      chk("restart clears err", 32'(dl_err), 32'd0);
      for (int i = 0; i < 32'h4000; i++) send(25'(i), 8'($urandom), 8'd0, "short");
      end_dl();
      chk("short dl_err", 32'(dl_err), 32'(2'b10));
      check_hold_exit(1'b0, "short");

      start_dl();
      for (int i = 0; i < 100; i++) send(25'($urandom_range(0, 32'h601F)), 8'($urandom), 8'd0, "pre reset");
      ioctl_wr = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      check_reset_vals("mid reset");
      reset     = 1'b0;
      m_loading = 1'b0;
      m_count   = 0;
      m_err0    = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) send(25'($urandom_range(0, 32'h601F)), 8'($urandom), 8'd0, "after reset");
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      tick();
      chk("idle core_reset", 32'(core_reset), 32'd1);

      start_dl();
      for (int i = 0; i < 32'h6020; i++) begin
         if (i == 32'h601F) ioctl_download = 1'b0;
         send(25'(i), 8'($urandom), 8'd0, "full");
      end
      ioctl_wr  = 1'b0;
      m_loading = 1'b0;
      chk("full last sel", 32'(rom_sel), 32'(4'b1000));
      chk("full last addr", 32'(rom_addr), 32'h1F);
      chk("full dl_err", 32'(dl_err), 32'd0);
      chk("full byte_count", 32'(byte_count), 32'h6020);
      check_hold_exit(1'b1, "full");

      start_dl();
      chk("rerun core_reset", 32'(core_reset), 32'd1);
      chk("rerun dl_done", 32'(dl_done), 32'd0);
      chk("rerun byte_count", 32'(byte_count), 32'd0);
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         ri   = 8'd0;
         if (kind < 7)       ra = 25'($urandom_range(0, 32'h601F));
         else if (kind == 7) ra = 25'($urandom_range(32'h6020, 32'hFFFF));
         else if (kind == 8) ra = {9'($urandom_range(1, 511)), 16'($urandom)};
         else begin
            ra = 25'($urandom_range(0, 32'h601F));
            ri = 8'($urandom_range(1, 255));
         end
         send(ra, 8'($urandom), ri, "random");
         if ($urandom_range(0, 2) == 0) begin
            ioctl_wr = 1'b0;
            tick();
            chk("random gap", 32'(rom_wr), 32'd0);
         end
      end
      end_dl();
      chk("random dl_err", 32'(dl_err), 32'(model_err()));
      check_hold_exit(model_err() == 2'b00, "random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_dl_router.md
Name: rom_dl_router

Overview:
- Sits between data_io and the galaxian core.
- Consumes the ioctl byte stream during an OSD ROM download and decodes each address into one of four ROM regions: PGM, 1K, 1H and 6L.
- Emits registered write strobes to the core's ROM loaders.
- Holds the core in reset until a complete, valid image has landed, and reports status flags for LED and OSD use.

Parameters:
- ROM_INDEX, 8'd0: ioctl_index value that selects the ROM download; writes carrying any other index are ignored.
- EXPECTED_SIZE, 17'h06020: byte count of a complete image.
- HOLD_CYCLES, 16: clk_sys cycles core_reset stays high after the download ends.

Ports:
- clk_sys, input, 1: system clock (12 MHz domain, same as data_io).
- reset, input, 1: synchronous, active-high.
- ioctl_download, input, 1: download-in-progress level from data_io.
- ioctl_index, input, 8: download index.
- ioctl_wr, input, 1: one-cycle byte-valid strobe.
- ioctl_addr, input, 25: byte address.
- ioctl_dout, input, 8: byte data.
- rom_wr, output, 1: one-cycle write strobe to the core.
- rom_addr, output, 16: region-relative address (offset within the selected region).
- rom_data, output, 8: write data.
- rom_sel, output, 4: one-hot region select, {6L,1H,1K,PGM}; valid only while rom_wr=1.
- core_reset, output, 1: reset request to the core.
- dl_done, output, 1: a valid image has been loaded.
- dl_err, output, 2: sticky error flags, {size_mismatch, out_of_range}.
- byte_count, output, 17: bytes accepted in the current or last download.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high, ports named clk_sys and reset.
- Reset values:
  - State = IDLE.
  - rom_wr=0, rom_addr=0, rom_data=0, rom_sel=0.
  - core_reset=1, dl_done=0, dl_err=0, byte_count=0.
- The download input is registered once internally for edge detection.
- The state machine leaves IDLE only on a rising edge of ioctl_download. A level that is already high when reset deasserts does not start a load.
- States:
  - IDLE: core_reset=1. A rising edge of ioctl_download moves to LOAD and clears byte_count, dl_err and dl_done.
  - LOAD: core_reset=1. For each ioctl_wr with ioctl_index==ROM_INDEX:
    - Address below 0x6020: accept the byte. Next cycle drive rom_wr=1 with rom_addr, rom_data and rom_sel (latency 1, no stall), and increment byte_count.
    - Address at or above 0x6020: no strobe; set dl_err[0]; byte_count unchanged.
    - Writes with a non-matching index are dropped silently and not counted.
    - On the falling edge of ioctl_download: go to HOLD, and set dl_err[1] if byte_count != EXPECTED_SIZE. The compare uses the count including any byte accepted in the same cycle as the fall.
  - HOLD: core_reset=1. The hold counter counts 0..HOLD_CYCLES-1, then the block moves to RUN if dl_err==0, otherwise back to IDLE. The core stays in reset after an error.
  - RUN: core_reset=0, dl_done=1. A rising edge of ioctl_download moves to LOAD with the same clears as from IDLE, and core_reset asserts the following cycle.
- Region decode on ioctl_addr[15:0], with rom_addr = addr minus region base:
  - 0x0000-0x3FFF → PGM (4'b0001).
  - 0x4000-0x4FFF → 1K (4'b0010).
  - 0x5000-0x5FFF → 1H (4'b0100).
  - 0x6000-0x601F → 6L (4'b1000).
- Any nonzero ioctl_addr[24:16] counts as out of range.
- ioctl_wr outside LOAD is ignored.
- rom_wr is never high for two consecutive cycles unless ioctl_wr was.
- A reset in mid-operation returns to the reset values. Writes are ignored until the next rising edge of ioctl_download.
- byte_count saturates at 17'h1FFFF.

Decomposition:
- Package rom_dl_pkg holds:
  - state enum {IDLE, LOAD, HOLD, RUN};
  - region base and limit localparams;
  - rom_sel one-hot encodings.
- One natural sub-module, rom_region_decode: purely combinational address → {sel, offset, out_of_range}.
- The state machine, counters and output registers stay in rom_dl_router.

Test Plan:
- Full download of 0x6020 bytes at index 0: 0x6020 strobes, the last with rom_sel=4'b1000 and rom_addr=0x1F; core_reset falls 16 cycles after download falls; dl_done=1; dl_err=0.
- Address 0x4005, data 0xA5: the next cycle gives rom_wr=1, rom_sel=4'b0010, rom_addr=0x0005, rom_data=0xA5.
- Download of only 0x4000 bytes: dl_err=2'b10; the block returns to IDLE after the hold; core_reset stays 1 and dl_done stays 0.
- Write to 0x6020 and to 0x1_0000 mid-download: no rom_wr; dl_err[0]=1; byte_count unchanged.
- ioctl_wr at index 1, and ioctl_wr with ioctl_download low: no strobes, byte_count stays 0.
- Reset asserted after 100 bytes with ioctl_download held high: all outputs return to reset values; further writes are ignored until download falls and rises again. A second full download then passes.
